// File: rtl/swt16_pkg.sv
// Width constants shared by every stage of the swt16 pipeline.
package swt16_pkg;

  localparam int DMEM_ADDR_WIDTH = 12;
  localparam int DMEM_WORD_WIDTH = 16;
  localparam int IALU_WORD_WIDTH = 16;
  localparam int PC_WIDTH        = 12;
  localparam int PMEM_WORD_WIDTH = 16;
  localparam int REG_IDX_WIDTH   = 4;

endpackage

// File: rtl/dmem_ram.sv
// Data memory array: one synchronous read port, one write port, no reset.
// A read of the address being written at the same edge returns the old word.
module dmem_ram #(
  parameter int ADDR_WIDTH = swt16_pkg::DMEM_ADDR_WIDTH,
  parameter int WORD_WIDTH = swt16_pkg::DMEM_WORD_WIDTH
) (
  input  logic                  clock,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [WORD_WIDTH-1:0] rd_data,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [WORD_WIDTH-1:0] wr_data
);

  logic [WORD_WIDTH-1:0] mem [2**ADDR_WIDTH];

  always_ff @(posedge clock) begin
    if (we)
      mem[wr_addr] <= wr_data;
    if (rd_en)
      rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/mem_access.sv
// Memory-access stage of swt16: commits stores, returns load data with
// store-to-load forwarding, arbitrates the preload port and counts accesses.
module mem_access #(
  parameter int DMEM_ADDR_WIDTH = swt16_pkg::DMEM_ADDR_WIDTH,
  parameter int DMEM_WORD_WIDTH = swt16_pkg::DMEM_WORD_WIDTH,
  parameter int IALU_WORD_WIDTH = swt16_pkg::IALU_WORD_WIDTH,
  parameter int PC_WIDTH        = swt16_pkg::PC_WIDTH,
  parameter int PMEM_WORD_WIDTH = swt16_pkg::PMEM_WORD_WIDTH,
  parameter int REG_IDX_WIDTH   = swt16_pkg::REG_IDX_WIDTH,
  parameter int CNT_WIDTH       = 16
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       in_act_load_dmem,
  input  logic                       in_act_store_dmem,
  input  logic                       in_act_write_res_to_reg,
  input  logic [DMEM_ADDR_WIDTH-1:0] in_dmem_rd_addr,
  input  logic [DMEM_ADDR_WIDTH-1:0] in_dmem_wr_addr,
  input  logic [DMEM_WORD_WIDTH-1:0] in_dmem_wr_word,
  input  logic [PMEM_WORD_WIDTH-1:0] in_instr,
  input  logic [PC_WIDTH-1:0]        in_pc,
  input  logic [IALU_WORD_WIDTH-1:0] in_res,
  input  logic [REG_IDX_WIDTH-1:0]   in_res_reg_idx,
  input  logic                       in_init_we,
  input  logic [DMEM_ADDR_WIDTH-1:0] in_init_addr,
  input  logic [DMEM_WORD_WIDTH-1:0] in_init_word,
  output logic                       out_act_write_res_to_reg,
  output logic [PMEM_WORD_WIDTH-1:0] out_instr,
  output logic [PC_WIDTH-1:0]        out_pc,
  output logic [IALU_WORD_WIDTH-1:0] out_res,
  output logic [REG_IDX_WIDTH-1:0]   out_res_reg_idx,
  output logic [CNT_WIDTH-1:0]       out_load_cnt,
  output logic [CNT_WIDTH-1:0]       out_store_cnt,
  output logic                       out_init_conflict
);

  logic                       load_ff;
  logic                       store_ff;
  logic                       write_res_ff;
  logic [DMEM_ADDR_WIDTH-1:0] wr_addr_ff;
  logic [DMEM_WORD_WIDTH-1:0] wr_word_ff;
  logic [PMEM_WORD_WIDTH-1:0] instr_ff;
  logic [PC_WIDTH-1:0]        pc_ff;
  logic [IALU_WORD_WIDTH-1:0] res_ff;
  logic [REG_IDX_WIDTH-1:0]   reg_idx_ff;
  logic                       fwd_ff;
  logic [DMEM_WORD_WIDTH-1:0] fwd_word_ff;
  logic [DMEM_WORD_WIDTH-1:0] ram_rd_data;
  logic [DMEM_WORD_WIDTH-1:0] rd_data;
  logic                       ram_we;
  logic [DMEM_ADDR_WIDTH-1:0] ram_wr_addr;
  logic [DMEM_WORD_WIDTH-1:0] ram_wr_data;

  // A committing store always owns the write port; init only fills idle slots.
  assign ram_we      = store_ff | in_init_we;
  assign ram_wr_addr = store_ff ? wr_addr_ff : in_init_addr;
  assign ram_wr_data = store_ff ? wr_word_ff : in_init_word;

  dmem_ram #(
    .ADDR_WIDTH(DMEM_ADDR_WIDTH),
    .WORD_WIDTH(DMEM_WORD_WIDTH)
  ) u_dmem_ram (
    .clock  (clock),
    .rd_en  (in_act_load_dmem),
    .rd_addr(in_dmem_rd_addr),
    .rd_data(ram_rd_data),
    .we     (ram_we),
    .wr_addr(ram_wr_addr),
    .wr_data(ram_wr_data)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      load_ff      <= 1'b0;
      store_ff     <= 1'b0;
      write_res_ff <= 1'b0;
      wr_addr_ff   <= '0;
      wr_word_ff   <= '0;
      instr_ff     <= '0;
      pc_ff        <= '0;
      res_ff       <= '0;
      reg_idx_ff   <= '0;
    end else begin
      load_ff      <= in_act_load_dmem;
      store_ff     <= in_act_store_dmem;
      write_res_ff <= in_act_write_res_to_reg;
      wr_addr_ff   <= in_dmem_wr_addr;
      wr_word_ff   <= in_dmem_wr_word;
      instr_ff     <= in_instr;
      pc_ff        <= in_pc;
      res_ff       <= in_res;
      reg_idx_ff   <= in_res_reg_idx;
    end
  end

  // The array returns the pre-store word when a load hits the committing
  // store's address, so remember that case and substitute the store data.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fwd_ff      <= 1'b0;
      fwd_word_ff <= '0;
    end else if (in_act_load_dmem) begin
      fwd_ff      <= store_ff && (wr_addr_ff == in_dmem_rd_addr);
      fwd_word_ff <= wr_word_ff;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      out_load_cnt      <= '0;
      out_store_cnt     <= '0;
      out_init_conflict <= 1'b0;
    end else begin
      if (in_act_load_dmem && (out_load_cnt != '1))
        out_load_cnt <= out_load_cnt + 1'b1;
      if (in_act_store_dmem && (out_store_cnt != '1))
        out_store_cnt <= out_store_cnt + 1'b1;
      if (in_init_we && store_ff)
        out_init_conflict <= 1'b1;
    end
  end

  assign rd_data                  = fwd_ff ? fwd_word_ff : ram_rd_data;
  assign out_res                  = load_ff ? rd_data : res_ff;
  assign out_act_write_res_to_reg = write_res_ff;
  assign out_instr                = instr_ff;
  assign out_pc                   = pc_ff;
  assign out_res_reg_idx          = reg_idx_ff;

endmodule

// File: tb/tb_mem_access.sv
// Scoreboard bench for mem_access: the driver queues expected write-back
// records, a monitor pops and compares them as tagged outputs appear.
module tb_mem_access;

  logic        clock;
  logic        reset;
  logic        in_act_load_dmem;
  logic        in_act_store_dmem;
  logic        in_act_write_res_to_reg;
  logic [11:0] in_dmem_rd_addr;
  logic [11:0] in_dmem_wr_addr;
  logic [15:0] in_dmem_wr_word;
  logic [15:0] in_instr;
  logic [11:0] in_pc;
  logic [15:0] in_res;
  logic [3:0]  in_res_reg_idx;
  logic        in_init_we;
  logic [11:0] in_init_addr;
  logic [15:0] in_init_word;
  logic        out_act_write_res_to_reg;
  logic [15:0] out_instr;
  logic [11:0] out_pc;
  logic [15:0] out_res;
  logic [3:0]  out_res_reg_idx;
  logic [15:0] out_load_cnt;
  logic [15:0] out_store_cnt;
  logic        out_init_conflict;

  typedef struct {
    logic        wr;
    logic [15:0] res;
    logic [3:0]  idx;
    logic [11:0] pc;
    logic [15:0] instr;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  mem_access dut (
    .clock                   (clock),
    .reset                   (reset),
    .in_act_load_dmem        (in_act_load_dmem),
    .in_act_store_dmem       (in_act_store_dmem),
    .in_act_write_res_to_reg (in_act_write_res_to_reg),
    .in_dmem_rd_addr         (in_dmem_rd_addr),
    .in_dmem_wr_addr         (in_dmem_wr_addr),
    .in_dmem_wr_word         (in_dmem_wr_word),
    .in_instr                (in_instr),
    .in_pc                   (in_pc),
    .in_res                  (in_res),
    .in_res_reg_idx          (in_res_reg_idx),
    .in_init_we              (in_init_we),
    .in_init_addr            (in_init_addr),
    .in_init_word            (in_init_word),
    .out_act_write_res_to_reg(out_act_write_res_to_reg),
    .out_instr               (out_instr),
    .out_pc                  (out_pc),
    .out_res                 (out_res),
    .out_res_reg_idx         (out_res_reg_idx),
    .out_load_cnt            (out_load_cnt),
    .out_store_cnt           (out_store_cnt),
    .out_init_conflict       (out_init_conflict)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%04h, expected 0x%04h", name, act, req);
    end
  endtask

  task automatic idleInputs();
    in_act_load_dmem        = 1'b0;
    in_act_store_dmem       = 1'b0;
    in_act_write_res_to_reg = 1'b0;
    in_dmem_rd_addr         = '0;
    in_dmem_wr_addr         = '0;
    in_dmem_wr_word         = '0;
    in_instr                = '0;
    in_pc                   = '0;
    in_res                  = '0;
    in_res_reg_idx          = '0;
    in_init_we              = 1'b0;
    in_init_addr            = '0;
    in_init_word            = '0;
  endtask

  // One instruction for one edge; pc != 0 tags it for the scoreboard.
  task automatic applyStimulus(input logic ld, input logic st, input logic wr,
                               input logic [11:0] rd_a, input logic [11:0] wr_a,
                               input logic [15:0] wr_w, input logic [15:0] res,
                               input logic [3:0] idx, input logic [11:0] pc,
                               input logic [15:0] exp_res);
    exp_t e;
    in_act_load_dmem        = ld;
    in_act_store_dmem       = st;
    in_act_write_res_to_reg = wr;
    in_dmem_rd_addr         = rd_a;
    in_dmem_wr_addr         = wr_a;
    in_dmem_wr_word         = wr_w;
    in_res                  = res;
    in_res_reg_idx          = idx;
    in_pc                   = pc;
    in_instr                = {4'hA, pc};
    if (pc != 0) begin
      e.wr = wr; e.res = exp_res; e.idx = idx; e.pc = pc; e.instr = {4'hA, pc};
      exp_q.push_back(e);
    end
    @(posedge clock);
    #1;
    idleInputs();
  endtask

  task automatic preload(input logic [11:0] a, input logic [15:0] w);
    in_init_we   = 1'b1;
    in_init_addr = a;
    in_init_word = w;
    @(posedge clock);
    #1;
    in_init_we   = 1'b0;
  endtask

  always @(negedge clock) begin
    if (!reset && out_pc != 0) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL unexpected_output: got pc 0x%03h, expected no output", out_pc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        checkOutput($sformatf("pc_%0d", e.pc), {4'h0, out_pc}, {4'h0, e.pc});
        checkOutput($sformatf("res_pc%0d", e.pc), out_res, e.res);
        checkOutput($sformatf("idx_pc%0d", e.pc), {12'h0, out_res_reg_idx}, {12'h0, e.idx});
        checkOutput($sformatf("wr_pc%0d", e.pc), {15'h0, out_act_write_res_to_reg}, {15'h0, e.wr});
        checkOutput($sformatf("instr_pc%0d", e.pc), out_instr, e.instr);
      end
    end
  end

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_res"}, out_res, 16'h0);
    checkOutput({tag, "_pc"}, {4'h0, out_pc}, 16'h0);
    checkOutput({tag, "_instr"}, out_instr, 16'h0);
    checkOutput({tag, "_idx"}, {12'h0, out_res_reg_idx}, 16'h0);
    checkOutput({tag, "_wr"}, {15'h0, out_act_write_res_to_reg}, 16'h0);
    checkOutput({tag, "_ldcnt"}, out_load_cnt, 16'h0);
    checkOutput({tag, "_stcnt"}, out_store_cnt, 16'h0);
    checkOutput({tag, "_conflict"}, {15'h0, out_init_conflict}, 16'h0);
  endtask

  initial begin
    idleInputs();
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    checkAllZero("reset");
    reset = 1'b0;
    @(posedge clock);
    #1;

    preload(12'h010, 16'hBEEF);
    applyStimulus(1, 0, 1, 12'h010, 12'h000, 16'h0000, 16'h0000, 4'd3, 12'd1, 16'hBEEF);

    // Store followed immediately by a load of the same address is forwarded.
    applyStimulus(0, 1, 0, 12'h000, 12'h020, 16'h1234, 16'h0011, 4'd0, 12'd2, 16'h0011);
    applyStimulus(1, 0, 1, 12'h020, 12'h000, 16'h0000, 16'h0000, 4'd5, 12'd3, 16'h1234);
    applyStimulus(0, 1, 0, 12'h000, 12'h020, 16'h5678, 16'h0022, 4'd0, 12'd4, 16'h0022);
    applyStimulus(0, 0, 0, 12'h000, 12'h000, 16'h0000, 16'h0000, 4'd0, 12'd0, 16'h0000);
    applyStimulus(1, 0, 1, 12'h020, 12'h000, 16'h0000, 16'h0000, 4'd6, 12'd5, 16'h5678);

    applyStimulus(0, 0, 1, 12'h010, 12'h000, 16'h0000, 16'h00A5, 4'd7, 12'd6, 16'h00A5);

    preload(12'h030, 16'h7777);
    checkOutput("conflict_clear", {15'h0, out_init_conflict}, 16'h0);
    applyStimulus(0, 1, 0, 12'h000, 12'h040, 16'h4444, 16'h0033, 4'd0, 12'd7, 16'h0033);
    preload(12'h030, 16'h9999);
    checkOutput("conflict_set", {15'h0, out_init_conflict}, 16'h1);
    applyStimulus(1, 0, 1, 12'h040, 12'h000, 16'h0000, 16'h0000, 4'd8, 12'd8, 16'h4444);
    applyStimulus(1, 0, 1, 12'h030, 12'h000, 16'h0000, 16'h0000, 4'd9, 12'd9, 16'h7777);
    repeat (3) @(posedge clock);
    #1;
    checkOutput("conflict_sticky", {15'h0, out_init_conflict}, 16'h1);
    checkOutput("ldcnt_5", out_load_cnt, 16'd5);
    checkOutput("stcnt_3", out_store_cnt, 16'd3);

    // Store sampled, reset hits before its commit edge.
    applyStimulus(0, 1, 0, 12'h000, 12'h040, 16'hDEAD, 16'h0044, 4'd0, 12'd0, 16'h0000);
    reset = 1'b1;
    #1;
    checkAllZero("midreset");
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock);
    #1;
    applyStimulus(1, 0, 1, 12'h040, 12'h000, 16'h0000, 16'h0000, 4'd10, 12'd11, 16'h4444);
    applyStimulus(0, 1, 0, 12'h000, 12'h050, 16'h0101, 16'h0055, 4'd0, 12'd12, 16'h0055);
    checkOutput("ldcnt_1", out_load_cnt, 16'd1);
    checkOutput("stcnt_1", out_store_cnt, 16'd1);

    in_act_load_dmem = 1'b1;
    in_dmem_rd_addr  = 12'h010;
    repeat (32'h10000) @(posedge clock);
    #1;
    in_act_load_dmem = 1'b0;
    checkOutput("ldcnt_sat", out_load_cnt, 16'hFFFF);
    checkOutput("stcnt_keep", out_store_cnt, 16'd1);
    repeat (3) @(posedge clock);
    #1;
    checkOutput("ldcnt_nowrap", out_load_cnt, 16'hFFFF);

    repeat (2) @(posedge clock);
    #1;
    while (exp_q.size() != 0) begin
      exp_t e;
      e = exp_q.pop_front();
      checks++;
      failures++;
      $display("[TB] FAIL missing_output: got nothing, expected pc 0x%03h", e.pc);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_access.md
# mem_access

Memory-access stage of the swt16 pipeline, placed directly after `exec`. It is the responder for the EX-stage load/store request interface: it owns the data memory array, commits stores, and returns load data. It forwards the ALU result or load data with its register index to write-back. Store-to-load forwarding and saturating access counters are included.

## Interface
Parameters:
- DMEM_ADDR_WIDTH, 12, data memory word-address width; array depth 2**DMEM_ADDR_WIDTH
- DMEM_WORD_WIDTH, 16, data memory word width; must equal IALU_WORD_WIDTH
- IALU_WORD_WIDTH, 16, ALU result width
- PC_WIDTH, 12, program counter width
- PMEM_WORD_WIDTH, 16, instruction word width
- REG_IDX_WIDTH, 4, register index width
- CNT_WIDTH, 16, access counter width

Ports:
- clock  in  1  clock; all state changes on rising edge
- reset  in  1  reset, asynchronous, active-high; clock clock
- in_act_load_dmem  in  1  load request from EX
- in_act_store_dmem  in  1  store request from EX
- in_act_write_res_to_reg  in  1  instruction writes a register
- in_dmem_rd_addr  in  DMEM_ADDR_WIDTH  load word address
- in_dmem_wr_addr  in  DMEM_ADDR_WIDTH  store word address
- in_dmem_wr_word  in  DMEM_WORD_WIDTH  store data
- in_instr  in  PMEM_WORD_WIDTH  instruction, passed through
- in_pc  in  PC_WIDTH  PC, passed through
- in_res  in  IALU_WORD_WIDTH  ALU result
- in_res_reg_idx  in  REG_IDX_WIDTH  destination register
- in_init_we, in_init_addr, in_init_word  in  1 / DMEM_ADDR_WIDTH / DMEM_WORD_WIDTH  bench preload write port
- out_act_write_res_to_reg  out  1  to write-back
- out_instr, out_pc  out  PMEM_WORD_WIDTH / PC_WIDTH  passed through
- out_res  out  IALU_WORD_WIDTH  load data or ALU result
- out_res_reg_idx  out  REG_IDX_WIDTH  destination register
- out_load_cnt, out_store_cnt  out  CNT_WIDTH  saturating access counters
- out_init_conflict  out  1  sticky: an init write was dropped

## Operation
- All inputs are sampled into `_ff` registers on every rising edge. No flush input exists because EX already zeroes the request and control signals on flush.
- Read port, synchronous:
  - At edge E with in_act_load_dmem=1, rd_data_ff <= mem[in_dmem_rd_addr].
  - Forwarding case: if store_ff=1 and wr_addr_ff==in_dmem_rd_addr at the same edge, rd_data_ff <= wr_word_ff.
- Write port: at edge E, if store_ff=1 then mem[wr_addr_ff] <= wr_word_ff. A store therefore commits one edge after it is sampled.
- Init port: at edge E, if in_init_we=1 and store_ff=0, then mem[in_init_addr] <= in_init_word.
  - If in_init_we=1 and store_ff=1, the store wins, the init write is dropped, and out_init_conflict is set.
  - out_init_conflict stays set until reset.
- out_res = load_ff ? rd_data_ff : res_ff.
- The other outputs are combinational copies of their `_ff` registers.
- A load and a store sampled at the same edge are both legal.
- Counters:
  - out_load_cnt increments at each edge where in_act_load_dmem=1.
  - out_store_cnt increments at each edge where in_act_store_dmem=1.
  - Both saturate at all-ones and do not wrap.
- Address arithmetic: none. Addresses are word indices used unmodified. Out-of-range is impossible by width.

## Timing
- Latency: 1 edge from input to output for all fields, including load data.
- Forwarding covers the only read-during-write hazard: a store at edge E followed by a load to the same address at E+1. All other store-to-load gaps read the array directly.
- Reset, asynchronous:
  - All `_ff` registers, rd_data_ff, counters and out_init_conflict go to 0, so every output is 0.
  - The memory array is not reset; its contents are undefined until written.
- Reset asserted mid-operation: a store sampled but not yet committed is discarded and never written.

## Structure
- Shared package `swt16_pkg` holds the width constants used by all stages: DMEM_ADDR_WIDTH, DMEM_WORD_WIDTH, IALU_WORD_WIDTH, PC_WIDTH, PMEM_WORD_WIDTH, REG_IDX_WIDTH.
- One sub-module, `dmem_ram`: 1 synchronous-read port and 1 write port, no reset, read-old-data on an address collision. Forwarding and the init arbiter live in mem_access.

## Test plan
- Preload mem[0x010]=0xBEEF via init; load rd_addr=0x010, reg_idx=3, write_res=1 -> next edge out_res=0xBEEF, out_res_reg_idx=3, out_act_write_res_to_reg=1.
- Store 0x1234 to 0x020, then a load of 0x020 on the immediately following edge -> out_res=0x1234 (forwarded); repeat with one idle cycle between -> 0x1234 read from the array.
- Non-load instruction with in_res=0x00A5, idx=7 -> out_res=0x00A5, idx=7 one edge later; rd_data is ignored.
- Init write to 0x030 issued on the same edge a store commits to 0x040 -> mem[0x040] updated, mem[0x030] unchanged, out_init_conflict=1 until reset.
- Issue 0x10000 loads with CNT_WIDTH=16 -> out_load_cnt holds 0xFFFF and does not wrap; out_store_cnt unchanged.
- Assert reset between store sampling and commit -> all outputs 0; a later load of that address returns the old value.
